// File: rtl/bgr_pkg.sv
// Shared types for the BGR chroma-key stream framer: pixel modes, control states, per-pixel tags.
// Holds no logic. Nothing here adds latency or has a backpressure role.
package bgr_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        KEY  = 2'b01,
        MASK = 2'b10,
        RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        FINISH = 2'b10
    } state_e;

    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 20;

    // Per-pixel tags carried alongside the data through both pipeline stages
    typedef struct packed {
        logic last;
        logic user;
        logic eof;
    } meta_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bgr_key_compare.sv
// Per-channel key match: |pix - key| <= thresh on every channel, using an extra bit so nothing overflows.
// Purely combinational with zero latency. It has no flow control of its own.
module bgr_key_compare #(
    parameter int DATA_WIDTH = 24
) (
    input  logic [DATA_WIDTH-1:0]   pix,
    input  logic [DATA_WIDTH-1:0]   key,
    input  logic [DATA_WIDTH/3-1:0] thresh,
    output logic                    match
);

    localparam int CH_W = DATA_WIDTH / 3;

    logic [2:0] ch_ok;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [CH_W:0] p;
        logic [CH_W:0] k;
        logic [CH_W:0] d;

        assign p        = {1'b0, pix[c*CH_W +: CH_W]};
        assign k        = {1'b0, key[c*CH_W +: CH_W]};
        assign d        = (p >= k) ? (p - k) : (k - p);
        assign ch_ok[c] = (d <= {1'b0, thresh});
    end

    assign match = &ch_ok;

endmodule

// File: rtl/bgr_stream_framer.sv
// Frames a pixel stream into rows and frames, applying pass, key-replace or mask. Latency is 2 cycles.
// A stalled output freezes both stages, and S_AXIS_READY follows M_AXIS_READY combinationally.
module bgr_stream_framer
    import bgr_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTn,
    input  logic                    i_START_STREAM,
    input  logic [1:0]              i_MODE,
    input  logic [DATA_WIDTH-1:0]   i_KEY_COLOR,
    input  logic [DATA_WIDTH/3-1:0] i_THRESH,
    input  logic [DATA_WIDTH-1:0]   i_FILL_COLOR,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_DATA,
    input  logic                    S_AXIS_VALID,
    output logic                    S_AXIS_READY,
    output logic [DATA_WIDTH-1:0]   M_AXIS_DATA,
    output logic                    M_AXIS_VALID,
    input  logic                    M_AXIS_READY,
    output logic                    M_AXIS_LAST,
    output logic                    M_AXIS_USER,
    output logic                    o_FRAME_DONE,
    output logic                    o_BUSY
);

    localparam int CH_W  = DATA_WIDTH / 3;
    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_e                state;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;

    mode_e                 cfg_mode;
    logic [DATA_WIDTH-1:0] cfg_key;
    logic [DATA_WIDTH-1:0] cfg_fill;
    logic [CH_W-1:0]       cfg_thresh;

    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_dat;
    meta_t                 s1_meta;
    mode_e                 s1_mode;

    logic                  s2_vld;
    logic [DATA_WIDTH-1:0] s2_dat;
    meta_t                 s2_meta;

    logic                  advance;
    logic                  in_xfer;
    logic                  at_origin;
    logic                  at_eol;
    logic                  at_eof;
    logic                  s1_match;
    mode_e                 frame_mode;
    logic [DATA_WIDTH-1:0] result;

    assign advance      = !s2_vld || M_AXIS_READY;
    assign S_AXIS_READY = (state == STREAM) && advance;
    assign in_xfer      = S_AXIS_VALID && S_AXIS_READY;

    assign at_origin  = (col == '0) && (row == '0);
    assign at_eol     = (col == COL_LAST);
    assign at_eof     = at_eol && (row == ROW_LAST);
    // The first pixel of a frame must use the mode being latched with it, not the stale one
    assign frame_mode = at_origin ? mode_e'(i_MODE) : cfg_mode;

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_START_STREAM)
                        state <= STREAM;
                end
                STREAM: begin
                    if (in_xfer && at_eof && !i_START_STREAM)
                        state <= FINISH;
                end
                FINISH: begin
                    if (!s1_vld && !s2_vld)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            col        <= '0;
            row        <= '0;
            cfg_mode   <= PASS;
            cfg_key    <= '0;
            cfg_fill   <= '0;
            cfg_thresh <= '0;
        end else if (in_xfer) begin
            if (at_origin) begin
                cfg_mode   <= mode_e'(i_MODE);
                cfg_key    <= i_KEY_COLOR;
                cfg_fill   <= i_FILL_COLOR;
                cfg_thresh <= i_THRESH;
            end
            if (at_eol) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    bgr_key_compare #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_key_compare (
        .pix    (s1_dat),
        .key    (cfg_key),
        .thresh (cfg_thresh),
        .match  (s1_match)
    );

    always_comb begin
        result = s1_dat;
        case (s1_mode)
            KEY:     if (s1_match) result = cfg_fill;
            MASK:    result = s1_match ? '0 : '1;
            default: result = s1_dat;
        endcase
    end

    // Both stages move together, so a stall at the output holds every in-flight pixel in place
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s1_meta <= '0;
            s1_mode <= PASS;
            s2_vld  <= 1'b0;
            s2_dat  <= '0;
            s2_meta <= '0;
        end else if (advance) begin
            s1_vld <= in_xfer;
            if (in_xfer) begin
                s1_dat       <= S_AXIS_DATA;
                s1_meta.last <= at_eol;
                s1_meta.user <= at_origin;
                s1_meta.eof  <= at_eof;
                s1_mode      <= frame_mode;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dat  <= result;
                s2_meta <= s1_meta;
            end
        end
    end

    assign M_AXIS_VALID = s2_vld;
    assign M_AXIS_DATA  = s2_dat;
    assign M_AXIS_LAST  = s2_meta.last;
    assign M_AXIS_USER  = s2_meta.user;
    assign o_FRAME_DONE = s2_vld && M_AXIS_READY && s2_meta.eof;
    assign o_BUSY       = (state != IDLE);

endmodule

// File: tb/tb_bgr_stream_framer.sv
// Directed bench: a 4x2 instance covers pass/key/mask, start drop and reset; a 320x20 instance covers random backpressure.
module tb_bgr_stream_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, s_vld, s_rdy, m_vld, m_rdy, m_last, m_user, done, busy;
    logic [1:0]  mode;
    logic [23:0] key, fill, s_dat, m_dat;
    logic [7:0]  thresh;

    logic        start_b, s_vld_b, s_rdy_b, m_vld_b, m_rdy_b, m_last_b, m_user_b, done_b, busy_b;
    logic [1:0]  mode_b;
    logic [23:0] s_dat_b, m_dat_b;

    bgr_stream_framer #(.DATA_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
        .i_CLK(clk), .i_RSTn(rst_n), .i_START_STREAM(start), .i_MODE(mode),
        .i_KEY_COLOR(key), .i_THRESH(thresh), .i_FILL_COLOR(fill),
        .S_AXIS_DATA(s_dat), .S_AXIS_VALID(s_vld), .S_AXIS_READY(s_rdy),
        .M_AXIS_DATA(m_dat), .M_AXIS_VALID(m_vld), .M_AXIS_READY(m_rdy),
        .M_AXIS_LAST(m_last), .M_AXIS_USER(m_user), .o_FRAME_DONE(done), .o_BUSY(busy)
    );

    bgr_stream_framer #(.DATA_WIDTH(24), .IMG_WIDTH(320), .IMG_HEIGHT(20)) dut_big (
        .i_CLK(clk), .i_RSTn(rst_n), .i_START_STREAM(start_b), .i_MODE(mode_b),
        .i_KEY_COLOR(key), .i_THRESH(thresh), .i_FILL_COLOR(fill),
        .S_AXIS_DATA(s_dat_b), .S_AXIS_VALID(s_vld_b), .S_AXIS_READY(s_rdy_b),
        .M_AXIS_DATA(m_dat_b), .M_AXIS_VALID(m_vld_b), .M_AXIS_READY(m_rdy_b),
        .M_AXIS_LAST(m_last_b), .M_AXIS_USER(m_user_b), .o_FRAME_DONE(done_b), .o_BUSY(busy_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Small-instance monitor: input/output transfers are sampled on the falling edge
    int          cyc = 0;
    logic [23:0] o_dat_q[$];
    bit          o_last_q[$], o_user_q[$], o_done_q[$];
    int          o_cyc_q[$], i_cyc_q[$];
    int          done_cnt = 0;
    int          in_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_vld && s_rdy) begin
            i_cyc_q.push_back(cyc);
            in_cnt++;
        end
        if (m_vld && m_rdy) begin
            o_dat_q.push_back(m_dat);
            o_last_q.push_back(m_last);
            o_user_q.push_back(m_user);
            o_done_q.push_back(done);
            o_cyc_q.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    // Big-instance monitor: order, tag positions and hold-during-stall
    int          bo_cnt = 0, ord_err = 0, stab_err = 0, blast = 0, buser = 0, bdone = 0;
    logic        pv_b = 1'b0, pr_b = 1'b0, pl_b = 1'b0, pu_b = 1'b0;
    logic [23:0] pd_b = '0;

    always @(negedge clk) begin
        if (pv_b && !pr_b) begin
            if (!m_vld_b || m_dat_b !== pd_b || m_last_b !== pl_b || m_user_b !== pu_b) stab_err++;
        end
        if (m_vld_b && m_rdy_b) begin
            if (m_dat_b !== 24'(bo_cnt)) ord_err++;
            if (m_last_b !== ((bo_cnt % 320) == 319)) ord_err++;
            if (m_user_b !== (bo_cnt == 0)) ord_err++;
            if (m_last_b) blast++;
            if (m_user_b) buser++;
            bo_cnt++;
        end
        if (done_b) bdone++;
        pv_b = m_vld_b; pr_b = m_rdy_b; pd_b = m_dat_b; pl_b = m_last_b; pu_b = m_user_b;
    end

    logic [23:0] e_dat[$];

    task automatic send(input logic [23:0] pix, input logic [23:0] exp);
        int n;
        n = 0;
        s_vld = 1'b1;
        s_dat = pix;
        @(negedge clk);
        while (!s_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_rdy) check_eq("send_rdy", 32'(s_rdy), 32'd1);
        e_dat.push_back(exp);
        @(posedge clk); #1;
    endtask

    task automatic clear_queues();
        o_dat_q.delete(); o_last_q.delete(); o_user_q.delete(); o_done_q.delete();
        o_cyc_q.delete(); i_cyc_q.delete(); e_dat.delete();
    endtask

    // key 0x102030, thresh 5, fill 0x00FF00
    logic [23:0] f2_in [8] = '{24'h152535, 24'h162030, 24'h102030, 24'h0B1B2B,
                               24'h0A2030, 24'h10202A, 24'h152535, 24'h000000};
    logic [23:0] f2_exp[8] = '{24'h00FF00, 24'h162030, 24'h00FF00, 24'h00FF00,
                               24'h0A2030, 24'h10202A, 24'h00FF00, 24'h000000};
    logic [23:0] f3_in [8] = '{24'h0B1B2B, 24'hFFFFFF, 24'h102030, 24'h102036,
                               24'h152535, 24'h000000, 24'h0F1F2F, 24'h112131};
    logic [23:0] f3_exp[8] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                               24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};

    initial begin
        int n;
        int idx;
        logic acc;
        logic [23:0] pix;

        rst_n = 1'b0; start = 1'b0; s_vld = 1'b0; s_dat = '0; mode = 2'b00;
        key = '0; thresh = '0; fill = '0; m_rdy = 1'b1;
        start_b = 1'b0; s_vld_b = 1'b0; s_dat_b = '0; m_rdy_b = 1'b1; mode_b = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_rdy", 32'(s_rdy), 0);
        check_eq("rst_m_vld", 32'(m_vld), 0);
        check_eq("rst_m_dat", 32'(m_dat), 0);
        check_eq("rst_last", 32'(m_last), 0);
        check_eq("rst_user", 32'(m_user), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b1;

        // Frame 1: pass mode, continuous input
        for (int i = 0; i < 8; i++) begin
            pix = 24'h0F1E2D + 24'(i) * 24'h010203;
            send(pix, pix);
        end

        // Frame 2: key-replace; config for frame 3 is changed after its first pixel
        mode = 2'b01; key = 24'h102030; thresh = 8'h05; fill = 24'h00FF00;
        send(f2_in[0], f2_exp[0]);
        mode = 2'b10; fill = 24'h123456;
        for (int i = 1; i < 8; i++) send(f2_in[i], f2_exp[i]);

        // Frame 3: mask
        send(f3_in[0], f3_exp[0]);
        mode = 2'b00;
        for (int i = 1; i < 8; i++) send(f3_in[i], f3_exp[i]);

        // Frame 4: pass, start dropped after the third pixel
        for (int i = 0; i < 8; i++) begin
            pix = 24'hA00000 + 24'(i);
            send(pix, pix);
            if (i == 2) start = 1'b0;
        end
        s_vld = 1'b0;

        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq("drain_busy", 32'(busy), 0);
        check_eq("drain_out_cnt", 32'(o_dat_q.size()), 32);
        check_eq("frame_done_cnt", 32'(done_cnt), 4);
        @(posedge clk); #1;
        s_vld = 1'b1; s_dat = 24'hDEADBE;
        @(negedge clk);
        check_eq("idle_s_rdy", 32'(s_rdy), 0);
        @(posedge clk); #1;
        s_vld = 1'b0;
        @(negedge clk);
        check_eq("idle_in_cnt", 32'(in_cnt), 32);

        check_eq("latency", 32'(o_cyc_q[0] - i_cyc_q[0]), 2);
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("dat%0d", i), 32'(o_dat_q[i]), 32'(e_dat[i]));
            check_eq($sformatf("last%0d", i), 32'(o_last_q[i]), 32'((i % 4) == 3));
            check_eq($sformatf("user%0d", i), 32'(o_user_q[i]), 32'((i % 8) == 0));
            check_eq($sformatf("done%0d", i), 32'(o_done_q[i]), 32'((i % 8) == 7));
        end

        // Reset in the middle of a frame, then restart
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) send(24'h330000 + 24'(i), 24'h330000 + 24'(i));
        s_vld = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mrst_m_vld", 32'(m_vld), 0);
        check_eq("mrst_m_dat", 32'(m_dat), 0);
        check_eq("mrst_last", 32'(m_last), 0);
        check_eq("mrst_user", 32'(m_user), 0);
        check_eq("mrst_done", 32'(done), 0);
        check_eq("mrst_busy", 32'(busy), 0);
        check_eq("mrst_s_rdy", 32'(s_rdy), 0);
        @(posedge clk); #1;
        clear_queues();
        for (int i = 0; i < 8; i++) send(24'h5A0000 + 24'(i), 24'h5A0000 + 24'(i));
        s_vld = 1'b0;
        n = 0;
        while (o_dat_q.size() < 8 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq("restart_cnt", 32'(o_dat_q.size()), 8);
        check_eq("restart_user0", 32'(o_user_q[0]), 1);
        check_eq("restart_dat0", 32'(o_dat_q[0]), 32'h5A0000);
        check_eq("restart_user1", 32'(o_user_q[1]), 0);
        check_eq("restart_last3", 32'(o_last_q[3]), 1);
        start = 1'b0;

        // Full-size frame with 50% random output backpressure
        @(posedge clk); #1;
        idx = 0;
        start_b = 1'b1; s_vld_b = 1'b1; s_dat_b = '0;
        n = 0;
        while (idx < 6400 && n < 40000) begin
            n++;
            @(negedge clk);
            acc = s_rdy_b;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx == 1) start_b = 1'b0;
            end
            s_dat_b = 24'(idx);
            if (idx == 6400) s_vld_b = 1'b0;
            m_rdy_b = 1'($urandom_range(0, 1));
        end
        check_eq("big_in_cnt", 32'(idx), 6400);
        m_rdy_b = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy_b && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq("big_busy", 32'(busy_b), 0);
        check_eq("big_out_cnt", 32'(bo_cnt), 6400);
        check_eq("big_order_err", 32'(ord_err), 0);
        check_eq("big_stable_err", 32'(stab_err), 0);
        check_eq("big_last_cnt", 32'(blast), 20);
        check_eq("big_user_cnt", 32'(buser), 1);
        check_eq("big_done_cnt", 32'(bdone), 1);
        check_eq("big_s_rdy", 32'(s_rdy_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bgr_stream_framer.md
BGR_STREAM_FRAMER -- requirements
Module: bgr_stream_framer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 24, pixel width (3 equal channels, DATA_WIDTH divisible by 3); IMG_WIDTH, 320, pixels per row; IMG_HEIGHT, 20, rows per frame.
REQ-002 SHALL have ports:
- i_CLK  in  1  single clock, all logic on rising edge.
- i_RSTn  in  1  reset, synchronous, active-low.
- i_START_STREAM  in  1  level; enables frame streaming.
- i_MODE  in  2  00 pass, 01 key-replace, 10 mask, 11 treated as pass.
- i_KEY_COLOR  in  DATA_WIDTH  background key colour.
- i_THRESH  in  DATA_WIDTH/3  per-channel match tolerance.
- i_FILL_COLOR  in  DATA_WIDTH  replacement colour for mode 01.
- S_AXIS_DATA  in  DATA_WIDTH  input pixel.
- S_AXIS_VALID  in  1.
- S_AXIS_READY  out  1.
- M_AXIS_DATA  out  DATA_WIDTH  output pixel.
- M_AXIS_VALID  out  1.
- M_AXIS_READY  in  1.
- M_AXIS_LAST  out  1  last pixel of row.
- M_AXIS_USER  out  1  first pixel of frame.
- o_FRAME_DONE  out  1  one-cycle pulse per completed frame.
- o_BUSY  out  1  high whenever state is not IDLE.

Function
REQ-003 SHALL implement states IDLE, STREAM and FINISH.
REQ-004 IDLE->STREAM SHALL occur on the first cycle i_START_STREAM=1.
REQ-005 In STREAM, on acceptance of the last input pixel of a frame: stay in STREAM if i_START_STREAM=1, else go to FINISH.
REQ-006 FINISH->IDLE SHALL occur when both pipeline stages are empty.
REQ-007 An input transfer SHALL be S_AXIS_VALID && S_AXIS_READY; an output transfer SHALL be M_AXIS_VALID && M_AXIS_READY.
REQ-008 Pipeline advance SHALL be !M_AXIS_VALID || M_AXIS_READY.
REQ-009 S_AXIS_READY SHALL equal (state==STREAM) && advance; it may depend combinationally on M_AXIS_READY.
REQ-010 The datapath SHALL be a 2-stage pipeline, latency 2 cycles from input transfer to M_AXIS_VALID, throughput 1 pixel/cycle while M_AXIS_READY=1.
REQ-011 Stage 1 SHALL register the pixel, row/column tags and the frame mode. Stage 2 SHALL register the result.
REQ-012 While M_AXIS_VALID=1 and M_AXIS_READY=0, M_AXIS_DATA, M_AXIS_LAST and M_AXIS_USER SHALL hold stable, and no pixel SHALL be dropped or duplicated.
REQ-013 Column counter SHALL run 0..IMG_WIDTH-1 and row counter 0..IMG_HEIGHT-1, advancing on input transfers only; both wrap to 0 after pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-014 The pixel at col=IMG_WIDTH-1 SHALL be tagged LAST; the pixel at (0,0) SHALL be tagged USER.
REQ-015 i_MODE, i_KEY_COLOR, i_THRESH and i_FILL_COLOR SHALL be latched on the (0,0) input transfer; changes mid-frame SHALL take effect at the next frame.
REQ-016 A pixel SHALL match when, for every channel, |pix_ch - key_ch| <= thresh, using unsigned compare at channel width plus 1 bit with no overflow.
REQ-017 Output per mode: pass -> pixel unchanged; key-replace -> fill colour if match, else pixel; mask -> all zeros if match, else all ones.
REQ-018 o_FRAME_DONE SHALL pulse for one cycle on the output transfer of the pixel tagged LAST at row IMG_HEIGHT-1.
REQ-019 i_START_STREAM falling mid-frame SHALL NOT truncate the frame; the frame completes, then the block passes through FINISH to IDLE.
REQ-020 When the last input transfer and an output stall coincide, the input SHALL still be accepted only if advance=1; there SHALL be no skid loss.

Reset
REQ-021 When i_RSTn=0 at a clock edge, the block SHALL enter IDLE, clear both counters, clear both stage valids and clear the latched config to pass mode.
REQ-022 During and after reset: S_AXIS_READY=0, M_AXIS_VALID=0, M_AXIS_DATA=0, M_AXIS_LAST=0, M_AXIS_USER=0, o_FRAME_DONE=0, o_BUSY=0.
REQ-023 Reset mid-frame SHALL discard in-flight pixels; the next frame SHALL restart at (0,0).

Structure
REQ-024 Package bgr_pkg SHALL hold the mode enum (PASS, KEY, MASK, RSVD), the state enum (IDLE, STREAM, FINISH) and default IMG_WIDTH/IMG_HEIGHT constants.
REQ-025 Sub-module bgr_key_compare SHALL be combinational and parametrised by DATA_WIDTH; it takes pixel, key and thresh and outputs match; it is instantiated in stage 1->2.

Verification
REQ-026 Pass mode, IMG_WIDTH=4, IMG_HEIGHT=2, 8 continuous pixels, M_AXIS_READY=1 -> identical data out 2 cycles later; LAST on outputs 4 and 8; USER on output 1; o_FRAME_DONE pulses once on output 8.
REQ-027 Mode 01, key=0x102030, thresh=0x05, fill=0x00FF00; inputs 0x152535 and 0x162030 -> outputs 0x00FF00 and 0x162030.
REQ-028 Mode 10, same key/thresh; inputs 0x0B1B2B and 0xFFFFFF -> outputs 0x000000 and 0xFFFFFF.
REQ-029 Random M_AXIS_READY toggling (50%) over one 320x20 frame -> 6400 outputs in order, data stable during stalls, exactly 20 LAST, 1 USER.
REQ-030 i_START_STREAM dropped at pixel 3 of an 8-pixel frame -> all 8 pixels output, o_FRAME_DONE pulses, o_BUSY falls after the drain, S_AXIS_READY=0 afterwards.
REQ-031 i_RSTn=0 for one cycle mid-frame -> all outputs are 0 the next cycle; after restart the first output carries USER=1.
